tl_tick_debounce: RTL and testbench

Front-end stage feeding the traffic-light FSM. It produces a single-cycle time-base tick (one FSM step per tick) from the system clock through a runtime-programmable prescaler. It also synchronises and debounces the raw start pushbutton into a clean one-cycle start request and a stable level. A start request re-phases the prescaler, so the first light interval after a start is exactly one full tick period.

---
 rtl/tl_tick_debounce.sv | 139 +++++++++++++
 tb/tb_tl_tick_debounce.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tl_tick_debounce.sv
// rtl/tl_tick_debounce.sv - programmable time-base tick and start-button debouncer
// Start acceptance re-phases the prescaler so the first interval after a start is a full period.
module tl_tick_debounce #(
  parameter int DIV_W     = 24,
  parameter int DB_CYCLES = 16,
  parameter int DB_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             btn_raw,
  output logic             tick,
  output logic             start_req,
  output logic             btn_level,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE_LO   = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } db_state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  db_state_t        r_state;
  db_state_t        w_state_nxt;
  logic [DB_W-1:0]  r_dbc;
  logic [DB_W-1:0]  w_dbc_nxt;
  logic             w_accept;
  logic             w_level_nxt;
  logic             w_busy_nxt;
  logic             r_btn_level;
  logic             r_start_req;
  logic             r_busy;
  logic [DIV_W-1:0] r_pc;
  logic             r_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE_LO;
      r_dbc       <= '0;
      r_btn_level <= 1'b0;
      r_start_req <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dbc       <= w_dbc_nxt;
      r_btn_level <= w_level_nxt;
      r_start_req <= w_accept;
      r_busy      <= w_busy_nxt;
    end
  end

  // Only a rising acceptance raises w_accept; falling acceptance just drops the level.
  always_comb begin
    w_state_nxt = r_state;
    w_dbc_nxt   = r_dbc;
    w_accept    = 1'b0;
    w_level_nxt = r_btn_level;
    case (r_state)
      IDLE_LO: begin
        if (r_sync2) begin
          w_state_nxt = CHK_HI;
          w_dbc_nxt   = '0;
        end
      end
      CHK_HI: begin
        if (!r_sync2) begin
          w_state_nxt = IDLE_LO;
        end else if (r_dbc == DB_LAST) begin
          w_state_nxt = STABLE_HI;
          w_level_nxt = 1'b1;
          w_accept    = 1'b1;
        end else begin
          w_dbc_nxt = r_dbc + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!r_sync2) begin
          w_state_nxt = CHK_LO;
          w_dbc_nxt   = '0;
        end
      end
      CHK_LO: begin
        if (r_sync2) begin
          w_state_nxt = STABLE_HI;
        end else if (r_dbc == DB_LAST) begin
          w_state_nxt = IDLE_LO;
          w_level_nxt = 1'b0;
        end else begin
          w_dbc_nxt = r_dbc + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE_LO;
        w_dbc_nxt   = '0;
      end
    endcase
    w_busy_nxt = (w_state_nxt == CHK_HI) || (w_state_nxt == CHK_LO);
  end

  // Start re-phase wins over terminal count and applies regardless of en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc   <= '0;
      r_tick <= 1'b0;
    end else if (w_accept || !en) begin
      r_pc   <= '0;
      r_tick <= 1'b0;
    end else if (r_pc >= div_val) begin
      r_pc   <= '0;
      r_tick <= 1'b1;
    end else begin
      r_pc   <= r_pc + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign tick      = r_tick;
  assign start_req = r_start_req;
  assign btn_level = r_btn_level;
  assign busy      = r_busy;

endmodule

// File: tb/tb_tl_tick_debounce.sv
// tb/tb_tl_tick_debounce.sv - scoreboard bench for tl_tick_debounce
module tb_tl_tick_debounce;
  localparam int DIV_W     = 24;
  localparam int DB_CYCLES = 16;
  localparam int DB_W      = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [DIV_W-1:0] div_val;
  logic             btn_raw;
  logic             tick;
  logic             start_req;
  logic             btn_level;
  logic             busy;

  typedef struct {
    logic tick;
    logic sr;
    logic lvl;
    logic busy;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   failures  = 0;
  int   dut_ticks = 0;

  // reference state: edge index, edge of last prescaler restart, mismatch run length
  int   edge_n   = 0;
  int   last_clr = 0;
  int   run      = 0;
  logic m_level  = 1'b0;
  logic h1       = 1'b0;
  logic h2       = 1'b0;

  tl_tick_debounce #(.DIV_W(DIV_W), .DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) dut (
    .clk(clk), .rst(rst), .en(en), .div_val(div_val), .btn_raw(btn_raw),
    .tick(tick), .start_req(start_req), .btn_level(btn_level), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // A level change is accepted once the synchronised input has differed from the
  // accepted level on DB_CYCLES+1 consecutive edges; a tick fires once div_val+1
  // edges have elapsed since the last restart of the period.
  function automatic void model();
    exp_t x;
    logic sync;
    logic acc;
    edge_n++;
    if (rst) begin
      h1 = 1'b0; h2 = 1'b0; run = 0; m_level = 1'b0; last_clr = edge_n;
      x = '{1'b0, 1'b0, 1'b0, 1'b0};
    end else begin
      sync = h2;
      h2   = h1;
      h1   = btn_raw;
      acc  = 1'b0;
      if (sync != m_level) begin
        run++;
        if (run == DB_CYCLES + 1) begin
          m_level = sync;
          run     = 0;
          acc     = sync;
        end
      end else begin
        run = 0;
      end
      x.sr   = acc;
      x.lvl  = m_level;
      x.busy = (run != 0);
      if (acc || !en) begin
        x.tick   = 1'b0;
        last_clr = edge_n;
      end else if (edge_n - 1 - last_clr >= int'(div_val)) begin
        x.tick   = 1'b1;
        last_clr = edge_n;
      end else begin
        x.tick = 1'b0;
      end
    end
    sb.push_back(x);
  endfunction

  task automatic step(input logic r, input logic e, input logic [DIV_W-1:0] d, input logic b);
    if (r && !rst) sb.delete();
    rst = r; en = e; div_val = d; btn_raw = b;
    @(posedge clk);
    model();
    #2;
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (tick === 1'b1) dut_ticks++;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check("tick", 32'(tick), 32'(x.tick));
      check("start_req", 32'(start_req), 32'(x.sr));
      check("btn_level", 32'(btn_level), 32'(x.lvl));
      check("busy", 32'(busy), 32'(x.busy));
    end
  end

  initial begin
    int snap;
    int len;
    logic e;
    logic b;
    logic [DIV_W-1:0] d;
    rst = 1'b1; en = 1'b0; div_val = '0; btn_raw = 1'b0;
    repeat (3) step(1'b1, 1'b0, 24'd0, 1'b0);
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_start_req", 32'(start_req), 32'd0);
    check("reset_btn_level", 32'(btn_level), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // steady period of 5, then div_val=0
    repeat (10) step(1'b0, 1'b1, 24'd4, 1'b0);
    snap = dut_ticks;
    repeat (100) step(1'b0, 1'b1, 24'd4, 1'b0);
    check("ticks_in_100", 32'(dut_ticks - snap), 32'd20);
    repeat (10) step(1'b0, 1'b1, 24'd0, 1'b0);

    // async reset mid-count with button accepted
    repeat (30) step(1'b0, 1'b1, 24'd9, 1'b1);
    repeat (5) step(1'b0, 1'b1, 24'd9, 1'b1);
    rst = 1'b1;
    sb.delete();
    #1;
    check("async_tick", 32'(tick), 32'd0);
    check("async_start_req", 32'(start_req), 32'd0);
    check("async_btn_level", 32'(btn_level), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    repeat (2) step(1'b1, 1'b1, 24'd9, 1'b0);
    repeat (25) step(1'b0, 1'b1, 24'd9, 1'b0);

    // glitch shorter than debounce window
    repeat (10) step(1'b0, 1'b1, 24'd9, 1'b1);
    repeat (30) step(1'b0, 1'b1, 24'd9, 1'b0);

    // long hold then release
    repeat (220) step(1'b0, 1'b1, 24'd9, 1'b1);
    repeat (40) step(1'b0, 1'b1, 24'd9, 1'b0);

    // start acceptance swept across every prescaler phase (div_val=7)
    for (int off = 0; off < 8; off++) begin
      repeat (off) step(1'b0, 1'b1, 24'd7, 1'b0);
      repeat (25) step(1'b0, 1'b1, 24'd7, 1'b1);
      repeat (25) step(1'b0, 1'b1, 24'd7, 1'b0);
    end

    // re-phase with en low
    repeat (25) step(1'b0, 1'b0, 24'd3, 1'b1);
    repeat (25) step(1'b0, 1'b1, 24'd3, 1'b0);

    // lower div_val below the running count
    repeat (70) step(1'b0, 1'b1, 24'd100, 1'b0);
    repeat (50) step(1'b0, 1'b1, 24'd20, 1'b0);

    // randomized segments
    for (int s = 0; s < 150; s++) begin
      len = $urandom_range(1, 40);
      e   = ($urandom_range(0, 9) != 0);
      b   = $urandom_range(0, 1);
      d   = DIV_W'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) repeat (2) step(1'b1, e, d, b);
      repeat (len) step(1'b0, e, d, b);
    end

    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
